// File: rtl/overlay_rom_sequencer_pkg.sv
// Shared definitions for the overlay ROM sequencer: pixel width, default
// colours and the line-tracking state encoding.
package overlay_rom_sequencer_pkg;

  localparam int RGB_W = 24;

  localparam logic [RGB_W-1:0] DEF_BG_COLOUR  = 24'h000000;
  localparam logic [RGB_W-1:0] DEF_KEY_COLOUR = 24'hff00ff;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'b00,
    LINE       = 2'b01,
    BLANK      = 2'b10
  } seqState_t;

endpackage

// File: rtl/overlay_rom_sequencer_if.sv
// Image ROM read port: the sequencer drives address/enable, the ROM returns
// pixel data a fixed number of cycles later.
interface overlay_rom_sequencer_if
  import overlay_rom_sequencer_pkg::*;
#(
  parameter int ADDR_W = 12
);

  logic [ADDR_W-1:0] romAddr;
  logic              romRen;
  logic [RGB_W-1:0]  romData;

  modport master (output romAddr, output romRen, input romData);
  modport slave  (input romAddr, input romRen, output romData);

endinterface

// File: rtl/overlay_rom_sequencer_delay_line.sv
// Fixed-depth shift register that clears to zero on reset; used to carry
// data-enable and window flags alongside the ROM read latency.
module delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_p [DEPTH];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/overlay_rom_sequencer.sv
// Places a ROM-stored picture as a rectangular window over a background
// colour on the active-video stream, compensating for ROM read latency.
module overlay_rom_sequencer
  import overlay_rom_sequencer_pkg::*;
#(
  parameter int               H_ACTIVE    = 1920,
  parameter int               V_ACTIVE    = 1080,
  parameter int               WIN_X0      = 0,
  parameter int               WIN_Y0      = 0,
  parameter int               WIN_W       = 64,
  parameter int               WIN_H       = 64,
  parameter int               ROM_LATENCY = 2,
  parameter logic [RGB_W-1:0] BG_COLOUR   = DEF_BG_COLOUR,
  parameter bit               KEY_EN      = 1'b0,
  parameter logic [RGB_W-1:0] KEY_COLOUR  = DEF_KEY_COLOUR,
  parameter int               ADDR_W      = $clog2(WIN_W * WIN_H)
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      frameStart,
  input  logic                      deIn,
  overlay_rom_sequencer_if.master   rom,
  output logic [RGB_W-1:0]          dataOutput,
  output logic                      deOut
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [XW-1:0]     X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [XW:0]       X_ORG    = (XW+1)'(WIN_X0);
  localparam logic [XW:0]       X_SPAN   = (XW+1)'(WIN_W);
  localparam logic [YW:0]       Y_ORG    = (YW+1)'(WIN_Y0);
  localparam logic [YW:0]       Y_SPAN   = (YW+1)'(WIN_H);
  localparam logic [YW:0]       Y_END    = (YW+1)'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIN_W);
  localparam logic [ADDR_W-1:0] BASE_MAX = ADDR_W'(WIN_W * (WIN_H - 1));

  function automatic logic [XW-1:0] satInc(input logic [XW-1:0] v);
    return (v == X_LAST) ? v : v + XW'(1);
  endfunction

  function automatic logic yInWin(input logic [YW-1:0] v);
    logic [YW:0] off;
    off = {1'b0, v} - Y_ORG;
    return off < Y_SPAN;
  endfunction

  function automatic logic keyed(input logic [RGB_W-1:0] px);
    return KEY_EN && (px == KEY_COLOUR);
  endfunction

  seqState_t         state, stateNext;
  logic [XW-1:0]     x, xNext, pixX;
  logic              xOver, xOverNext, pixOver;
  logic [YW-1:0]     y, yNext, pixY;
  logic [ADDR_W-1:0] rowBase, baseNext, pixBase;
  logic [XW:0]       xOff;
  logic [YW:0]       yOff;
  logic              pixValid, inWin, lastLine;

  assign lastLine = ({1'b0, y} + (YW+1)'(1)) == Y_END;

  // Current pixel position: frameStart overrides whatever the tracker held,
  // and a deIn rise in BLANK already belongs to the next line.
  always_comb begin
    stateNext = state;
    xNext     = x;
    xOverNext = xOver;
    yNext     = y;
    baseNext  = rowBase;
    pixValid  = 1'b0;
    pixX      = x;
    pixOver   = xOver;
    pixY      = y;
    pixBase   = rowBase;
    if (frameStart) begin
      stateNext = LINE;
      pixValid  = deIn;
      pixX      = '0;
      pixOver   = 1'b0;
      pixY      = '0;
      pixBase   = '0;
      xNext     = '0;
      xOverNext = 1'b0;
      yNext     = '0;
      baseNext  = '0;
    end else begin
      unique case (state)
        WAIT_FRAME: begin
        end
        LINE: begin
          if (deIn) begin
            pixValid = 1'b1;
          end else begin
            stateNext = BLANK;
            xNext     = '0;
            xOverNext = 1'b0;
          end
        end
        BLANK: begin
          if (deIn) begin
            if (lastLine) begin
              stateNext = WAIT_FRAME;
            end else begin
              stateNext = LINE;
              pixValid  = 1'b1;
              pixX      = '0;
              pixOver   = 1'b0;
              pixY      = y + YW'(1);
              pixBase   = (yInWin(y) && rowBase < BASE_MAX) ? rowBase + ROW_STEP : rowBase;
              yNext     = pixY;
              baseNext  = pixBase;
            end
          end
        end
        default: stateNext = WAIT_FRAME;
      endcase
    end
    if (pixValid) begin
      xNext     = satInc(pixX);
      xOverNext = pixOver | (pixX == X_LAST);
    end
    xOff  = {1'b0, pixX} - X_ORG;
    yOff  = {1'b0, pixY} - Y_ORG;
    inWin = pixValid && !pixOver && (xOff < X_SPAN) && (yOff < Y_SPAN);
  end

  // Stage p0: position tracker and registered ROM request
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= WAIT_FRAME;
      x           <= '0;
      xOver       <= 1'b0;
      y           <= '0;
      rowBase     <= '0;
      rom.romRen  <= 1'b0;
      rom.romAddr <= '0;
    end else begin
      state      <= stateNext;
      x          <= xNext;
      xOver      <= xOverNext;
      y          <= yNext;
      rowBase    <= baseNext;
      rom.romRen <= inWin;
      if (inWin) rom.romAddr <= pixBase + ADDR_W'(xOff);
    end
  end

  // Stage p1: enable/window flags aligned with returning ROM data
  logic [1:0] aligned_p1;
  logic       vld_p1, win_p1;

  delay_line #(
    .WIDTH (2),
    .DEPTH (ROM_LATENCY + 1)
  ) u_align (
    .clock  (clock),
    .resetN (resetN),
    .din    ({deIn, inWin}),
    .dout   (aligned_p1)
  );

  assign vld_p1 = aligned_p1[1];
  assign win_p1 = aligned_p1[0];

  // Stage p2: output mux register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dataOutput <= BG_COLOUR;
      deOut      <= 1'b0;
    end else begin
      deOut      <= vld_p1;
      dataOutput <= (vld_p1 && win_p1 && !keyed(rom.romData)) ? rom.romData : BG_COLOUR;
    end
  end

endmodule
